// File: rtl/around_sched.sv
// Byte-serial AddRoundKey sequencer: walks 16 state bytes FETCH -> XOR -> WRITE, addressing round-key bytes.
// Three cycles per byte with key_ready held high; FETCH stalls on key_ready=0; abort and n_rst cancel a run.
module around_sched (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [3:0] round_num,
    input  logic       key_ready,
    input  logic       abort,
    output logic       around_enable,
    output logic [3:0] byte_idx,
    output logic [7:0] key_addr,
    output logic       state_we,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, FETCH, XOR, WRITE, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (round_num <= 4'd10) begin
                        round_d = round_num;
                        idx_d   = 4'd0;
                        state_d = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: if (key_ready) state_d = XOR;
            XOR:   state_d = WRITE;
            WRITE: begin
                // 4-bit increment wraps 15 -> 0 on the final byte
                idx_d   = idx_q + 4'd1;
                state_d = (idx_q == 4'd15) ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks everything once a run is underway; the WRITE strobe of this cycle still fires
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = 4'd0;
        end
    end

    assign around_enable = (state_q == XOR);
    assign state_we      = (state_q == WRITE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign byte_idx      = idx_q;
    // round_q never exceeds 10, so the sum tops out at 175 and fits in 8 bits
    assign key_addr      = {round_q, 4'b0000} + {4'b0000, idx_q};

endmodule
